ser: RTL and testbench

SER -- requirements
Module: ser

---
 rtl/ser.sv | 135 +++++++++++++
 tb/tb_ser.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ser.sv
// ser: memory-mapped UART, 8N1, fixed BIT_CYCLES clocks per bit
// Ports: clk/rst (sync, active-high); en/adr/rd/wr/data_in/data_out form the CPU
// register port (adr 0 = data, adr 1 = status {ferr, ovr, tx_rdy, rx_rdy});
// rxd is the asynchronous serial input, txd the serial output (idle high).
module ser #(
  parameter int BIT_CYCLES = 217
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        adr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        rxd,
  output logic        txd
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_st_q, rx_st_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic [2:0] tx_idx_q, rx_idx_q;
  logic [7:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic txd_q, rx_s1_q, rx_s2_q, rx_prev_q, rx_rdy_q, ovr_q, ferr_q;
  logic tx_rdy, wr_data, rd_data, rd_stat, tx_tick, rx_tick, rx_done, rx_bad;
  logic rx_rdy_d, ovr_d, ferr_d, unused_hi;
  assign tx_rdy   = tx_st_q == IDLE;
  assign wr_data  = en & wr & ~adr;
  assign rd_data  = en & rd & ~adr;
  assign rd_stat  = en & rd & adr;
  assign tx_tick  = tx_cnt_q == LAST;
  assign rx_tick  = rx_cnt_q == LAST;
  assign rx_done  = rx_st_q == STOP && rx_tick && rx_s2_q;
  assign rx_bad   = rx_st_q == STOP && rx_tick && !rx_s2_q;
  // a data read coinciding with a new byte keeps rx_rdy set and suppresses overrun
  assign rx_rdy_d = rx_done | (rx_rdy_q & ~rd_data);
  assign ovr_d    = (rx_done & rx_rdy_q & ~rd_data) | (ovr_q & ~rd_stat);
  assign ferr_d   = rx_bad | (ferr_q & ~rd_stat);
  assign data_out = adr ? {28'h0, ferr_q, ovr_q, tx_rdy, rx_rdy_q} : {24'h0, rx_data_q};
  assign txd      = txd_q;
  assign unused_hi = ^data_in[31:8];
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q  <= IDLE;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      tx_sh_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      case (tx_st_q)
        IDLE: if (wr_data) begin
          tx_st_q  <= START;
          tx_sh_q  <= data_in[7:0];
          tx_cnt_q <= '0;
          txd_q    <= 1'b0;
        end
        START: begin
          tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + 1'b1;
          if (tx_tick) begin
            tx_st_q  <= DATA;
            tx_idx_q <= '0;
            txd_q    <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end
        end
        DATA: begin
          tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + 1'b1;
          if (tx_tick) begin
            tx_idx_q <= tx_idx_q + 1'b1;
            tx_st_q  <= tx_idx_q == 3'd7 ? STOP : DATA;
            txd_q    <= tx_idx_q == 3'd7 ? 1'b1 : tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end
        end
        STOP: begin
          tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + 1'b1;
          if (tx_tick) tx_st_q <= IDLE;
        end
      endcase
    end
  end
  // synchronizer and edge history reset low, so a line held low after reset
  // must first be seen high before a falling edge can start a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q   <= IDLE;
      rx_cnt_q  <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      rx_s1_q   <= 1'b0;
      rx_s2_q   <= 1'b0;
      rx_prev_q <= 1'b0;
      rx_rdy_q  <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_rdy_q  <= rx_rdy_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      if (rx_done) rx_data_q <= rx_sh_q;
      case (rx_st_q)
        IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_st_q  <= START;
          rx_cnt_q <= '0;
        end
        START: begin
          rx_cnt_q <= rx_cnt_q == HALF ? '0 : rx_cnt_q + 1'b1;
          if (rx_cnt_q == HALF) begin
            rx_st_q  <= rx_s2_q ? IDLE : DATA;
            rx_idx_q <= '0;
          end
        end
        DATA: begin
          rx_cnt_q <= rx_tick ? '0 : rx_cnt_q + 1'b1;
          if (rx_tick) begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_idx_q <= rx_idx_q + 1'b1;
            if (rx_idx_q == 3'd7) rx_st_q <= STOP;
          end
        end
        STOP: begin
          rx_cnt_q <= rx_tick ? '0 : rx_cnt_q + 1'b1;
          if (rx_tick) rx_st_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ser.sv
// tb_ser: randomized self-checking bench for ser against a frame-level model
module tb_ser;
  localparam int B = 8;
  // start edge is seen 2 clocks after the line falls, sampled B/2 later, then 9 bit periods to stop sample
  localparam int DONE_AT = 2 + B / 2 + 9 * B;
  logic clk = 1'b0;
  logic rst, en, adr, rd, wr, rxd, txd;
  logic [31:0] data_in, data_out;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] m_data;
  logic m_rdy, m_ovr, m_ferr;
  ser #(.BIT_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .en(en), .adr(adr), .rd(rd), .wr(wr),
    .data_in(data_in), .data_out(data_out), .rxd(rxd), .txd(txd)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] m_status();
    return {m_ferr, m_ovr, 1'b1, m_rdy};
  endfunction
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic peek(input logic a, output logic [31:0] v);
    en = 1'b0; rd = 1'b0; wr = 1'b0; adr = a;
    #1 v = data_out;
  endtask
  task automatic cpu_read(input logic a, output logic [31:0] v);
    @(negedge clk);
    en = 1'b1; rd = 1'b1; wr = 1'b0; adr = a;
    #1 v = data_out;
    @(negedge clk);
    en = 1'b0; rd = 1'b0;
    if (a) begin m_ovr = 1'b0; m_ferr = 1'b0; end
    else m_rdy = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 10 * B; c++) begin
      @(negedge clk);
      rxd = bits[c / B];
      if (rd_at >= 0 && c == rd_at) begin en = 1'b1; rd = 1'b1; wr = 1'b0; adr = 1'b0; end
      else if (rd_at >= 0 && c == rd_at + 1) begin en = 1'b0; rd = 1'b0; end
    end
    @(negedge clk);
    rxd = 1'b1;
    idle(4);
    if (stop) begin
      if (rd_at != DONE_AT) m_ovr = m_ovr | m_rdy;
      m_rdy = 1'b1;
      m_data = b;
    end else m_ferr = 1'b1;
  endtask
  task automatic tx_frame(input logic [7:0] b, input int busy_at);
    logic [9:0] bits;
    logic e;
    bits = {1'b1, b, 1'b0};
    @(negedge clk);
    en = 1'b1; wr = 1'b1; adr = 1'b0;
    data_in = $urandom();
    data_in[7:0] = b;
    for (int k = 0; k <= 10 * B; k++) begin
      @(negedge clk);
      if (k == busy_at) begin
        en = 1'b1; wr = 1'b1; adr = 1'b0;
        data_in = $urandom();
        data_in[7:0] = ~b;
      end else begin
        en = 1'b0; wr = 1'b0; adr = 1'b1;
      end
      #1;
      e = (k < 10 * B) ? bits[k / B] : 1'b1;
      n_checks++;
      if (txd !== e) begin
        n_fail++;
        $display("FAIL tx_bit byte=%h cycle=%0d: got %b want %b", b, k, txd, e);
      end
      if (k != busy_at) begin
        n_checks++;
        if (data_out[1] !== (k == 10 * B)) begin
          n_fail++;
          $display("FAIL tx_rdy byte=%h cycle=%0d: got %b want %b", b, k, data_out[1], k == 10 * B);
        end
      end
    end
  endtask
  task automatic rx_check(input logic [7:0] b);
    logic [31:0] v;
    send_frame(b, 1'b1, -1);
    @(negedge clk);
    peek(1'b1, v);
    n_checks++;
    if (v !== {28'h0, m_status()}) begin
      n_fail++;
      $display("FAIL rx_status byte=%h: got %h want %h", b, v, {28'h0, m_status()});
    end
    cpu_read(1'b0, v);
    n_checks++;
    if (v !== {24'h0, m_data}) begin
      n_fail++;
      $display("FAIL rx_data: got %h want %h", v, {24'h0, m_data});
    end
    peek(1'b1, v);
    n_checks++;
    if (v[3:0] !== m_status()) begin
      n_fail++;
      $display("FAIL rx_after_read: got %b want %b", v[3:0], m_status());
    end
  endtask
  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; en = 1'b0; adr = 1'b0; rd = 1'b0; wr = 1'b0; rxd = 1'b1; data_in = '0;
    m_data = '0; m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(4);
    n_checks++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
    peek(1'b0, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", v); end
    peek(1'b1, v);
    n_checks++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h want 2", v); end
  endtask
  task automatic test_tx();
    tx_frame(8'hA5, -1);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom()), -1);
  endtask
  task automatic test_rx();
    rx_check(8'h3C);
    for (int i = 0; i < 4; i++) rx_check(8'($urandom()));
  endtask
  task automatic test_overrun();
    logic [31:0] v;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    @(negedge clk);
    peek(1'b0, v);
    n_checks++;
    if (v !== {24'h0, m_data}) begin n_fail++; $display("FAIL ovr_data: got %h want %h", v, {24'h0, m_data}); end
    peek(1'b1, v);
    n_checks++;
    if (v[3:0] !== 4'b0111 || v[3:0] !== m_status()) begin
      n_fail++; $display("FAIL ovr_status: got %b want 0111", v[3:0]);
    end
    cpu_read(1'b1, v);
    peek(1'b1, v);
    n_checks++;
    if (v[3:0] !== m_status()) begin n_fail++; $display("FAIL ovr_cleared: got %b want %b", v[3:0], m_status()); end
    cpu_read(1'b0, v);
  endtask
  task automatic test_ferr();
    logic [31:0] v;
    rx_check(8'h5A);
    send_frame(8'($urandom()), 1'b0, -1);
    @(negedge clk);
    peek(1'b1, v);
    n_checks++;
    if (v[3:0] !== m_status()) begin n_fail++; $display("FAIL ferr_status: got %b want %b", v[3:0], m_status()); end
    peek(1'b0, v);
    n_checks++;
    if (v !== {24'h0, m_data}) begin n_fail++; $display("FAIL ferr_data: got %h want %h", v, {24'h0, m_data}); end
    cpu_read(1'b1, v);
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(6 * B);
    peek(1'b1, v);
    n_checks++;
    if (v[3:0] !== m_status()) begin n_fail++; $display("FAIL glitch_status: got %b want %b", v[3:0], m_status()); end
    peek(1'b0, v);
    n_checks++;
    if (v !== {24'h0, m_data}) begin n_fail++; $display("FAIL glitch_data: got %h want %h", v, {24'h0, m_data}); end
    rx_check(8'($urandom()));
  endtask
  task automatic test_busy_write();
    tx_frame(8'($urandom()), 20);
    tx_frame(8'($urandom()), 3 * B + 5);
  endtask
  task automatic test_reset_mid();
    logic [31:0] v;
    @(negedge clk);
    en = 1'b1; wr = 1'b1; adr = 1'b0; data_in = $urandom();
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
    rxd = 1'b0;
    idle(4 * B);
    rst = 1'b1;
    @(negedge clk);
    peek(1'b1, v);
    n_checks++;
    if (txd !== 1'b1 || v[1] !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_tx: got txd=%b tx_rdy=%b want 1 1", txd, v[1]);
    end
    rst = 1'b0;
    m_data = '0; m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    idle(3 * B);
    rxd = 1'b1;
    idle(2 * B);
    peek(1'b1, v);
    n_checks++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL rst_mid_status: got %h want 2", v); end
    peek(1'b0, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h want 0", v); end
    rx_check(8'($urandom()));
  endtask
  task automatic test_exact_read();
    logic [31:0] v;
    logic [7:0] b;
    b = 8'($urandom());
    send_frame(8'($urandom()), 1'b1, -1);
    send_frame(b, 1'b1, DONE_AT);
    @(negedge clk);
    peek(1'b1, v);
    n_checks++;
    if (v[3:0] !== 4'b0011 || v[3:0] !== m_status()) begin
      n_fail++; $display("FAIL exact_read_status: got %b want 0011", v[3:0]);
    end
    peek(1'b0, v);
    n_checks++;
    if (v !== {24'h0, b}) begin n_fail++; $display("FAIL exact_read_data: got %h want %h", v, {24'h0, b}); end
    cpu_read(1'b0, v);
  endtask
  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 2; i++) begin
      fork
        tx_frame(8'($urandom()), -1);
        send_frame(8'($urandom()), 1'b1, -1);
      join
      @(negedge clk);
      peek(1'b1, v);
      n_checks++;
      if (v[3:0] !== m_status()) begin n_fail++; $display("FAIL simul_status: got %b want %b", v[3:0], m_status()); end
      cpu_read(1'b0, v);
      n_checks++;
      if (v !== {24'h0, m_data}) begin n_fail++; $display("FAIL simul_data: got %h want %h", v, {24'h0, m_data}); end
    end
  endtask
  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_overrun();
    test_ferr();
    test_busy_write();
    test_reset_mid();
    test_exact_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
